// File: rtl/cpu_alu_seq.sv
// Sequential CPU ALU: result = B op A with C/V/N/Z flags, a start/busy/done
// handshake and an optional extra cycle for BCD correction on ADC/SBC.
module cpu_alu_seq #(
  parameter int unsigned W          = 8,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic         d,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         flag_wr,
  input  logic [3:0]   flag_d,
  output logic [W-1:0] result,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_n,
  output logic         flag_z,
  output logic         busy,
  output logic         done
);
  localparam int unsigned NIB     = W / 4;
  localparam bit          DEC_EFF = DECIMAL_EN && ((W % 4) == 0);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ADJ} state_e;
  typedef enum logic [3:0] {
    OP_PASS_A, OP_PASS_B, OP_ADC, OP_SBC, OP_OR, OP_AND, OP_EOR, OP_INC,
    OP_DEC, OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_CMP, OP_RSV14, OP_RSV15
  } op_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic           dec_q, dec_d, cin_q, cin_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           fc_q, fc_d, fv_q, fv_d, fn_q, fn_d, fz_q, fz_d;
  logic           busy_q, busy_d, done_q, done_d;

  // BCD add: nibble walk from the LSB, +6 correction on any nibble sum above 9
  function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W-1:0] r;
    logic         c;
    logic [5:0]   s;
    r = '0;
    c = cin;
    for (int i = 0; i < int'(NIB); i++) begin
      s = 6'(a[4*i +: 4]) + 6'(b[4*i +: 4]) + 6'(c);
      if (s > 6'd9) begin
        s = s + 6'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // BCD subtract: running borrow, -6 correction on any negative nibble difference
  function automatic logic [W:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W-1:0] r;
    logic         bw;
    logic [5:0]   s;
    r  = '0;
    bw = ~cin;
    for (int i = 0; i < int'(NIB); i++) begin
      s = 6'(b[4*i +: 4]) - 6'(a[4*i +: 4]) - 6'(bw);
      if (s[5]) begin
        s  = s - 6'd6;
        bw = 1'b1;
      end else begin
        bw = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {~bw, r};
  endfunction

  logic [W:0]   add_sum, sub_sum, cmp_diff, dec_sum, dec_diff;
  logic         add_v, sub_v;

  assign add_sum  = {1'b0, b_q} + {1'b0, a_q} + (W+1)'(cin_q);
  assign sub_sum  = {1'b0, b_q} + {1'b0, ~a_q} + (W+1)'(cin_q);
  assign cmp_diff = {1'b0, b_q} + {1'b0, ~a_q} + (W+1)'(1'b1);
  assign add_v    = (a_q[W-1] == b_q[W-1]) && (add_sum[W-1] != b_q[W-1]);
  assign sub_v    = (a_q[W-1] != b_q[W-1]) && (sub_sum[W-1] != b_q[W-1]);
  assign dec_sum  = bcd_add(a_q, b_q, cin_q);
  assign dec_diff = bcd_sub(a_q, b_q, cin_q);

  logic [W-1:0] ex_res, ex_nz;
  logic         ex_wr_nz, ex_c, ex_v;

  // Binary operation results; CMP takes N/Z from the difference, not the result
  always_comb begin
    ex_res   = result_q;
    ex_wr_nz = 1'b1;
    ex_c     = fc_q;
    ex_v     = fv_q;
    case (op_q)
      OP_PASS_A: ex_res = a_q;
      OP_PASS_B: ex_res = b_q;
      OP_ADC:    begin ex_res = add_sum[W-1:0]; ex_c = add_sum[W]; ex_v = add_v; end
      OP_SBC:    begin ex_res = sub_sum[W-1:0]; ex_c = sub_sum[W]; ex_v = sub_v; end
      OP_OR:     ex_res = b_q | a_q;
      OP_AND:    ex_res = b_q & a_q;
      OP_EOR:    ex_res = b_q ^ a_q;
      OP_INC:    ex_res = b_q + W'(1);
      OP_DEC:    ex_res = b_q - W'(1);
      OP_ASL:    begin ex_res = {b_q[W-2:0], 1'b0};  ex_c = b_q[W-1]; end
      OP_LSR:    begin ex_res = {1'b0, b_q[W-1:1]};  ex_c = b_q[0];   end
      OP_ROL:    begin ex_res = {b_q[W-2:0], cin_q}; ex_c = b_q[W-1]; end
      OP_ROR:    begin ex_res = {cin_q, b_q[W-1:1]}; ex_c = b_q[0];   end
      OP_CMP:    ex_c = cmp_diff[W];
      default:   begin ex_res = a_q; ex_wr_nz = 1'b0; end
    endcase
    ex_nz = (op_q == OP_CMP) ? cmp_diff[W-1:0] : ex_res;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dec_d    = dec_q;
    cin_d    = cin_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    fn_d     = fn_q;
    fz_d     = fz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d    = op_e'(op);
          dec_d   = d & DEC_EFF;
          cin_d   = fc_q;
          a_d     = A;
          b_d     = B;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end else if (flag_wr) begin
          {fc_d, fv_d, fn_d, fz_d} = flag_d;
        end
      end
      S_EXEC: begin
        if (dec_q && (op_q == OP_ADC || op_q == OP_SBC)) begin
          state_d = S_ADJ;
        end else begin
          result_d = ex_res;
          fc_d     = ex_c;
          fv_d     = ex_v;
          if (ex_wr_nz) begin
            fn_d = ex_nz[W-1];
            fz_d = (ex_nz == '0);
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ADJ: begin
        // V is always taken from the binary computation, C/N/Z from the BCD one
        if (op_q == OP_ADC) begin
          {fc_d, result_d} = dec_sum;
          fv_d             = add_v;
        end else begin
          {fc_d, result_d} = dec_diff;
          fv_d             = sub_v;
        end
        fn_d    = result_d[W-1];
        fz_d    = (result_d == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_PASS_A;
      dec_q    <= 1'b0;
      cin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dec_q    <= dec_d;
      cin_q    <= cin_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
      fn_q     <= fn_d;
      fz_q     <= fz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign flag_c = fc_q;
  assign flag_v = fv_q;
  assign flag_n = fn_q;
  assign flag_z = fz_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq: directed vectors, integer-arithmetic reference model
// checked every cycle, and a W=16 instance for wrap-around cases.
module tb_cpu_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, d, flag_wr;
  logic [3:0]  op, flag_d;
  logic [7:0]  A, B, result;
  logic        flag_c, flag_v, flag_n, flag_z, busy, done;

  logic        s_start, s_d, s_fwr;
  logic [3:0]  s_op, s_fd;
  logic [15:0] s_a, s_b, s_res;
  logic        s_c, s_v, s_n, s_z, s_busy, s_done;

  cpu_alu_seq #(.W(8), .DECIMAL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .d(d), .A(A), .B(B),
    .flag_wr(flag_wr), .flag_d(flag_d), .result(result), .flag_c(flag_c),
    .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z), .busy(busy), .done(done));

  cpu_alu_seq #(.W(16), .DECIMAL_EN(1'b1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .d(s_d), .A(s_a), .B(s_b),
    .flag_wr(s_fwr), .flag_d(s_fd), .result(s_res), .flag_c(s_c),
    .flag_v(s_v), .flag_n(s_n), .flag_z(s_z), .busy(s_busy), .done(s_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: architectural state after every issued op, plus a queue
  // of when each change becomes visible on the outputs.
  typedef struct { int due; logic dn; logic [7:0] res; logic [3:0] f; } ev_t;
  ev_t        evq[$];
  logic [7:0] m_res = 8'h00, v_res = 8'h00;
  logic [3:0] m_f = 4'h0, v_f = 4'h0;       // {C,V,N,Z}
  int         busy_lo = 0, busy_hi = 0;

  function automatic int bcd(input int a, input int b, input int cin, input bit add);
    int r, cy, s;
    r  = 0;
    cy = add ? cin : 1 - cin;
    for (int i = 0; i < 2; i++) begin
      if (add) begin
        s = (a >> (4*i)) % 16 + (b >> (4*i)) % 16 + cy;
        if (s > 9) begin s = s + 6; cy = 1; end else cy = 0;
      end else begin
        s = (b >> (4*i)) % 16 - (a >> (4*i)) % 16 - cy;
        if (s < 0) begin s = s - 6; cy = 1; end else cy = 0;
      end
      r = r + (((s % 16) + 16) % 16) * ((i == 0) ? 1 : 16);
    end
    return r + 256 * (add ? cy : 1 - cy);
  endfunction

  task automatic model(input logic [3:0] o, input logic dd, input int a, input int b,
                       output int lat);
    int c, r, s, sa, sb, nzv;
    bit cf, vf, nf, zf, wr_nz;
    {cf, vf, nf, zf} = m_f;
    c = int'(cf); r = int'(m_res); lat = 1; wr_nz = 1'b1;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    nzv = -1;
    case (o)
      4'd0:  r = a;
      4'd1:  r = b;
      4'd2: begin
        vf = ((sb + sa + c) > 127) || ((sb + sa + c) < -128);
        s  = dd ? bcd(a, b, c, 1'b1) : b + a + c;
        if (dd) lat = 2;
        r = s % 256; cf = (s >= 256);
      end
      4'd3: begin
        vf = ((sb - sa - (1 - c)) > 127) || ((sb - sa - (1 - c)) < -128);
        if (dd) begin
          s = bcd(a, b, c, 1'b0); lat = 2; r = s % 256; cf = (s >= 256);
        end else begin
          s = b - a - (1 - c); r = (s + 256) % 256; cf = (s >= 0);
        end
      end
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd6:  r = a ^ b;
      4'd7:  r = (b + 1) % 256;
      4'd8:  r = (b + 255) % 256;
      4'd9:  begin cf = (b >= 128); r = (b * 2) % 256; end
      4'd10: begin cf = (b % 2 == 1); r = b / 2; end
      4'd11: begin cf = (b >= 128); r = (b * 2) % 256 + c; end
      4'd12: begin cf = (b % 2 == 1); r = b / 2 + c * 128; end
      4'd13: begin cf = (b >= a); nzv = (b - a + 256) % 256; end
      default: begin r = a; wr_nz = 1'b0; end
    endcase
    if (nzv < 0) nzv = r;
    if (wr_nz) begin nf = (nzv >= 128); zf = (nzv == 0); end
    m_res = 8'(r);
    m_f   = {cf, vf, nf, zf};
  endtask

  // Every cycle after reset release: outputs must match the model's visible state
  always @(negedge clk) begin : cmp
    ev_t  ev;
    logic ed;
    if (chk_en) begin
      ed = 1'b0;
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        ev    = evq.pop_front();
        v_res = ev.res;
        v_f   = ev.f;
        ed    = ev.dn && (ev.due == cyc);
      end
      check("done", 16'(done), 16'(ed));
      check("busy", 16'(busy), 16'((cyc >= busy_lo) && (cyc < busy_hi)));
      check("result", 16'(result), 16'(v_res));
      check("flags", 16'({flag_c, flag_v, flag_n, flag_z}), 16'(v_f));
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] o, input logic dd, input logic fw,
                       input logic [7:0] a, input logic [7:0] b);
    int lat;
    start = 1'b1; op = o; d = dd; A = a; B = b;
    if (fw) begin flag_wr = 1'b1; flag_d = 4'hF; end
    model(o, dd, int'(a), int'(b), lat);
    busy_lo = cyc + 1;
    busy_hi = cyc + 1 + lat;
    evq.push_back('{cyc + 1 + lat, 1'b1, m_res, m_f});
    step();
    start = 1'b0; flag_wr = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < busy_hi) step();
  endtask

  task automatic fwr(input logic [3:0] f);
    flag_wr = 1'b1; flag_d = f;
    m_f = f;
    evq.push_back('{cyc + 1, 1'b0, m_res, f});
    step();
    flag_wr = 1'b0;
  endtask

  typedef struct { logic [3:0] o; logic dd; logic fw; logic [7:0] a, b, er; logic [3:0] ef; } vec_t;
  vec_t vecs[$];

  task automatic v(input logic [3:0] o, input logic dd, input logic fw, input logic [7:0] a,
                   input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    vecs.push_back('{o, dd, fw, a, b, er, ef});
  endtask

  // Issue each vector on the done cycle of the previous one, then pin literals
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      issue(vecs[i].o, vecs[i].dd, vecs[i].fw, vecs[i].a, vecs[i].b);
      wait_done();
      check($sformatf("v%0d_done", i), 16'(done), 16'd1);
      check($sformatf("v%0d_result", i), 16'(result), 16'(vecs[i].er));
      check($sformatf("v%0d_flags", i), 16'({flag_c, flag_v, flag_n, flag_z}), 16'(vecs[i].ef));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 4'h0; d = 1'b0; A = 8'h00; B = 8'h00;
    flag_wr = 1'b0; flag_d = 4'h0;
    s_start = 1'b0; s_op = 4'h0; s_d = 1'b0; s_a = 16'h0; s_b = 16'h0;
    s_fwr = 1'b0; s_fd = 4'h0;
    #1 rst_n = 1'b0;

    //   op     d     fw    A      B      result flags{C,V,N,Z}
    v(4'd2,  1'b0, 1'b0, 8'h50, 8'h50, 8'hA0, 4'b0110);
    v(4'd2,  1'b1, 1'b0, 8'h46, 8'h58, 8'h04, 4'b1100);
    v(4'd3,  1'b1, 1'b0, 8'h12, 8'h46, 8'h34, 4'b1000);
    v(4'd3,  1'b0, 1'b0, 8'h01, 8'h00, 8'hFF, 4'b0010);
    v(4'd13, 1'b0, 1'b0, 8'h10, 8'h10, 8'hFF, 4'b1001);
    v(4'd12, 1'b0, 1'b0, 8'h00, 8'h01, 8'h80, 4'b1010);
    v(4'd9,  1'b0, 1'b0, 8'h00, 8'h80, 8'h00, 4'b1001);
    v(4'd11, 1'b0, 1'b0, 8'h00, 8'h81, 8'h03, 4'b1000);
    v(4'd10, 1'b0, 1'b0, 8'h00, 8'h03, 8'h01, 4'b1000);
    v(4'd4,  1'b0, 1'b0, 8'h0F, 8'h30, 8'h3F, 4'b1000);
    v(4'd5,  1'b0, 1'b0, 8'h0F, 8'h30, 8'h00, 4'b1001);
    v(4'd6,  1'b0, 1'b0, 8'hFF, 8'h0F, 8'hF0, 4'b1010);
    v(4'd7,  1'b0, 1'b0, 8'h00, 8'h7F, 8'h80, 4'b1010);
    v(4'd8,  1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 4'b1010);
    v(4'd0,  1'b0, 1'b0, 8'h00, 8'h5A, 8'h00, 4'b1001);
    v(4'd1,  1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A, 4'b1000);
    v(4'd14, 1'b0, 1'b0, 8'h77, 8'h00, 8'h77, 4'b1000);
    v(4'd2,  1'b0, 1'b0, 8'h7F, 8'h01, 8'h81, 4'b0110);
    v(4'd3,  1'b0, 1'b0, 8'h01, 8'h80, 8'h7E, 4'b1100);
    v(4'd13, 1'b0, 1'b0, 8'h20, 8'h10, 8'h7E, 4'b0110);
    v(4'd3,  1'b1, 1'b0, 8'h01, 8'h00, 8'h98, 4'b0010);
    v(4'd2,  1'b1, 1'b0, 8'h99, 8'h01, 8'h00, 4'b1001);
    v(4'd2,  1'b1, 1'b0, 8'h0F, 8'h0F, 8'h15, 4'b0000);
    v(4'd1,  1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 4'b0001);
    v(4'd2,  1'b1, 1'b0, 8'h99, 8'h99, 8'h98, 4'b1110);
    v(4'd0,  1'b0, 1'b0, 8'h42, 8'h00, 8'h42, 4'b0000);

    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_result", 16'(result), 16'h0000);
    check("reset_flags", 16'({flag_c, flag_v, flag_n, flag_z}), 16'h0);
    check("reset_busy", 16'(busy), 16'd0);
    step();

    run_vecs(0, 4);
    fwr(4'b1000);
    check("flag_wr_load", 16'({flag_c, flag_v, flag_n, flag_z}), 16'(4'b1000));
    run_vecs(5, 23);

    // start during EXEC/ADJ must neither restart nor corrupt the decimal op
    issue(4'd2, 1'b1, 1'b0, 8'h11, 8'h22);
    step();
    start = 1'b1; op = 4'd1; A = 8'hEE; B = 8'hEE;
    step();
    start = 1'b0;
    check("ign_done", 16'(done), 16'd1);
    check("ign_result", 16'(result), 16'h0033);
    check("ign_flags", 16'({flag_c, flag_v, flag_n, flag_z}), 16'h0);

    run_vecs(24, 24);

    // asynchronous reset while a decimal op sits in ADJ
    issue(4'd2, 1'b1, 1'b0, 8'h01, 8'h01);
    step();
    check("adj_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    evq.delete();
    m_res = 8'h00; m_f = 4'h0; v_res = 8'h00; v_f = 4'h0;
    busy_lo = 0; busy_hi = 0;
    #1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_result", 16'(result), 16'h0000);
    check("rst_flags", 16'({flag_c, flag_v, flag_n, flag_z}), 16'h0);
    step();
    rst_n = 1'b1;
    run_vecs(25, 25);
    step(); step();

    // W=16: INC_B wrap, then DEC_B issued on the done cycle
    s_start = 1'b1; s_op = 4'd7; s_b = 16'hFFFF;
    step();
    s_start = 1'b0;
    check("w16_busy", 16'(s_busy), 16'd1);
    step();
    check("w16_inc_done", 16'(s_done), 16'd1);
    check("w16_inc_result", s_res, 16'h0000);
    check("w16_inc_flags", 16'({s_c, s_v, s_n, s_z}), 16'(4'b0001));
    s_start = 1'b1; s_op = 4'd8; s_b = 16'h0000;
    step();
    s_start = 1'b0;
    check("w16_b2b_busy", 16'(s_busy), 16'd1);
    step();
    check("w16_dec_done", 16'(s_done), 16'd1);
    check("w16_dec_result", s_res, 16'hFFFF);
    check("w16_dec_flags", 16'({s_c, s_v, s_n, s_z}), 16'(4'b0010));
    step();
    check("w16_done_pulse", 16'(s_done), 16'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_alu_seq.md
# cpu_alu_seq

Sequential, parametrised CPU ALU: `result = B op A` over a W-bit datapath. It owns the C/V/N/Z status flags and adds shift/rotate, compare, decrement and optional BCD (decimal) ADC/SBC. Operations are issued with a start/busy/done handshake. It sits between the register file/operand latches and the flag/result buses of the CPU core, replacing the purely combinational ALU.

## Interface
- `W`, 8: datapath width in bits, ≥ 4.
- `DECIMAL_EN`, 1: enables BCD correction. It is forced off when W is not a multiple of 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `start`  in  1  request an operation; accepted only when `busy`=0.
- `op`  in  4  operation code (see Operation).
- `d`  in  1  decimal mode for ADC/SBC, sampled with `start`.
- `A`  in  W  operand A, sampled with `start`.
- `B`  in  W  operand B, sampled with `start`.
- `flag_wr`  in  1  direct flag load; applies in IDLE only when `start`=0.
- `flag_d`  in  4  {C,V,N,Z} values for `flag_wr`.
- `result`  out  W  last written result (registered).
- `flag_c`, `flag_v`, `flag_n`, `flag_z`  out  1 each  status flags (registered).
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse; `result`/flags updated this cycle.

## Operation
- **States:** IDLE, EXEC, ADJ.
- **IDLE:**
  - `start`=1 latches `op`, `d`, `A`, `B` and the current C into internal registers, then goes to EXEC.
  - If `flag_wr`=1 and `start`=0, the flags load from `flag_d`.
- **EXEC:**
  - Decimal ADC/SBC (`d`=1, DECIMAL_EN effective) goes to ADJ.
  - Every other op writes `result`/flags, pulses `done` and returns to IDLE.
- **ADJ:** writes the decimal result/flags, pulses `done`, returns to IDLE.
- **Op codes** (unlisted flags hold their value):
  - 0 PASS_A: A; sets N,Z.
  - 1 PASS_B: B; sets N,Z.
  - 2 ADC: B+A+C; sets C = carry out, V = signed overflow, N, Z.
  - 3 SBC: B−A−(1−C); sets C = 1 if no borrow, V, N, Z.
  - 4 OR, 5 AND, 6 EOR: bitwise on B and A; sets N,Z.
  - 7 INC_B: B+1; 8 DEC_B: B−1. Both wrap mod 2^W and set N,Z; C unchanged.
  - 9 ASL: B<<1, C = B[W-1]. 10 LSR: B>>1, C = B[0]. Both set N,Z.
  - 11 ROL: {B[W-2:0],C}, C = B[W-1]. 12 ROR: {C,B[W-1:1]}, C = B[0]. Both set N,Z.
  - 13 CMP: computes B−A; sets C = (B ≥ A unsigned), N, Z from the difference; `result` unchanged.
  - 14, 15: reserved. `result` = A, all flags unchanged, `done` still pulses.
- **Flag definitions:** N = result MSB; Z = (result == 0).
- **Decimal ADC:** processed nibble by nibble from the LSB with a running carry c (initially C).
  - s = a+b+c. If s > 9, then s += 6 and c = 1; otherwise c = 0.
  - Final c → C. N and Z come from the decimal result; V comes from the binary sum.
- **Decimal SBC:** same nibble walk with borrow (initially 1−C).
  - s = b−a−borrow. If s < 0, then s −= 6 (mod 16) and borrow = 1.
  - C = 1−borrow. V comes from the binary difference.
- Non-BCD operand nibbles (> 9): result is the defined nibble arithmetic above; no error is flagged.
- `start` while `busy`=1 is ignored; the latched operands are not disturbed.

## Timing
- **Reset (`rst_n`=0, any state, asynchronous):** state = IDLE; `result` = 0; all flags = 0; `busy` = 0; `done` = 0. An operation in flight is discarded.
- **Acceptance:** `start` is accepted at edge T; `busy`=1 from T.
- **Binary ops:** `result`/flags update at edge T+1; `done`=1 and `busy`=0 during cycle T+1..T+2.
- **Decimal ADC/SBC:** update at edge T+2; `done` is high for the following cycle. `busy`=1 during cycles T..T+2.
- **Back-to-back:** `start` asserted while `done`=1 is accepted, giving one op per cycle for binary ops.
- **`flag_wr` with `start`:** `start` wins; `flag_wr` is dropped.
- Outputs are purely registered; no combinational path from inputs to outputs.

## Test plan
- W=8, C=0, ADC, A=0x50, B=0x50 → one cycle later `result`=0xA0, N=1, V=1, C=0, Z=0, single `done` pulse.
- W=8, C=0, d=1, ADC, A=0x46, B=0x58 → `result`=0x04, C=1, `done` two cycles after acceptance. Then C=1, d=1, SBC, B=0x46, A=0x12 → 0x34, C=1.
- C=1, SBC, B=0x00, A=0x01 → 0xFF, C=0, N=1, V=0. Then CMP, B=0x10, A=0x10 → Z=1, C=1, `result` still 0xFF.
- `flag_wr` {C=1,V=0,N=0,Z=0}, then ROR, B=0x01 → 0x80, C=1, N=1. Then ASL, B=0x80 → 0x00, C=1, Z=1.
- Start decimal ADC, then pulse `start` during ADJ (ignored). Deassert `rst_n` mid-ADJ → `busy`=0, `done`=0, `result`=0, all flags 0 immediately.
- W=16, C=0: INC_B B=0xFFFF → 0x0000, Z=1, C=0 unchanged. Back-to-back DEC_B B=0x0000 on the `done` cycle → 0xFFFF, N=1.
